// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
//   btn_state_t : per-channel FSM state (idle / pressed / long-held)
//   Def*Cycles  : default debounce, long-press and auto-repeat periods
//   cnt_width() : width of a counter that must hold values 0..n-1 (at least 1 bit)
package btn_cond_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPress,
    StLong
  } btn_state_t;

  localparam int unsigned DefDbCycles     = 16;
  localparam int unsigned DefLongCycles   = 1000;
  localparam int unsigned DefRepeatCycles = 250;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/btn_cond_channel.sv
// One button channel: two-flop synchroniser, stability-counter debounce and the
// press / long / repeat event FSM. All outputs are registered.
//   clk, rst_n     : clock, asynchronous active-low reset
//   btn            : raw asynchronous button level
//   repeat_en      : auto-repeat enable (already synchronous to clk)
//   held           : debounced level
//   press_pulse    : 1-cycle pulse on debounced rise
//   release_pulse  : 1-cycle pulse on debounced fall
//   long_pulse     : 1-cycle pulse when the hold reaches LONG_CYCLES
//   repeat_pulse   : 1-cycle pulse every REPEAT_CYCLES while long-held and enabled
module btn_cond_channel
  import btn_cond_pkg::*;
#(
  parameter int unsigned DB_CYCLES     = DefDbCycles,
  parameter int unsigned LONG_CYCLES   = DefLongCycles,
  parameter int unsigned REPEAT_CYCLES = DefRepeatCycles
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  input  logic repeat_en,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse
);

  localparam int unsigned DbW   = cnt_width(DB_CYCLES);
  localparam int unsigned HoldW = cnt_width(LONG_CYCLES);
  localparam int unsigned RepW  = cnt_width(REPEAT_CYCLES);

  localparam logic [DbW-1:0]   DbLast   = DbW'(DB_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_CYCLES - 1);
  localparam logic [RepW-1:0]  RepLast  = RepW'(REPEAT_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             held_q, held_d;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [RepW-1:0]  rep_cnt_q, rep_cnt_d;
  btn_state_t       state_q, state_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             long_q, long_d;
  logic             repeat_q, repeat_d;
  logic             rise, fall;

  // Debounce: the level must differ from held for DB_CYCLES consecutive edges.
  always_comb begin
    db_cnt_d = '0;
    held_d   = held_q;
    if (sync_q[1] != held_q) begin
      if (db_cnt_q == DbLast) begin
        held_d = ~held_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  assign rise = held_d & ~held_q;
  assign fall = ~held_d & held_q;

  // State register, counters and registered event pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      held_q     <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= StIdle;
      hold_cnt_q <= '0;
      rep_cnt_q  <= '0;
      press_q    <= 1'b0;
      release_q  <= 1'b0;
      long_q     <= 1'b0;
      repeat_q   <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], btn};
      held_q     <= held_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      rep_cnt_q  <= rep_cnt_d;
      press_q    <= press_d;
      release_q  <= release_d;
      long_q     <= long_d;
      repeat_q   <= repeat_d;
    end
  end

  // Next state. A fall always takes priority over the long threshold.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (rise) state_d = StPress;
      StPress: begin
        if (fall) begin
          state_d = StIdle;
        end else if (hold_cnt_q == HoldLast) begin
          state_d = StLong;
        end
      end
      StLong:  if (fall) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Event pulses and hold / repeat counters.
  always_comb begin
    hold_cnt_d = hold_cnt_q;
    rep_cnt_d  = rep_cnt_q;
    press_d    = 1'b0;
    release_d  = 1'b0;
    long_d     = 1'b0;
    repeat_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rise) begin
          press_d    = 1'b1;
          hold_cnt_d = '0;
        end
      end
      StPress: begin
        if (fall) begin
          release_d = 1'b1;
        end else if (hold_cnt_q == HoldLast) begin
          long_d     = 1'b1;
          hold_cnt_d = '0;
          rep_cnt_d  = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
        end
      end
      StLong: begin
        if (fall) begin
          release_d = 1'b1;
        end else if (!repeat_en) begin
          rep_cnt_d = '0;
        end else if (rep_cnt_q == RepLast) begin
          repeat_d  = 1'b1;
          rep_cnt_d = '0;
        end else begin
          rep_cnt_d = rep_cnt_q + RepW'(1);
        end
      end
      default: ;
    endcase
  end

  assign held          = held_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign long_pulse    = long_q;
  assign repeat_pulse  = repeat_q;

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel push-button front end; one independent conditioner per bit.
//   clk, rst_n : clock, asynchronous active-low reset
//   btn        : raw button levels
//   repeat_en  : per-channel auto-repeat enable
//   held_o     : debounced levels
//   press_o, release_o, long_o, repeat_o : per-channel 1-cycle event pulses
module btn_conditioner
  import btn_cond_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned DB_CYCLES     = DefDbCycles,
  parameter int unsigned LONG_CYCLES   = DefLongCycles,
  parameter int unsigned REPEAT_CYCLES = DefRepeatCycles
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] btn,
  input  logic [WIDTH-1:0] repeat_en,
  output logic [WIDTH-1:0] held_o,
  output logic [WIDTH-1:0] press_o,
  output logic [WIDTH-1:0] release_o,
  output logic [WIDTH-1:0] long_o,
  output logic [WIDTH-1:0] repeat_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    btn_cond_channel #(
      .DB_CYCLES    (DB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn[i]),
      .repeat_en    (repeat_en[i]),
      .held         (held_o[i]),
      .press_pulse  (press_o[i]),
      .release_pulse(release_o[i]),
      .long_pulse   (long_o[i]),
      .repeat_pulse (repeat_o[i])
    );
  end

endmodule

// File: tb/tb_btn_conditioner.sv
module tb_btn_conditioner;

  localparam int W  = 4;
  localparam int DB = 4;
  localparam int LG = 20;
  localparam int RP = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] btn, repeat_en;
  logic [W-1:0] held_o, press_o, release_o, long_o, repeat_o;

  always #5 clk = ~clk;

  btn_conditioner #(
    .WIDTH        (W),
    .DB_CYCLES    (DB),
    .LONG_CYCLES  (LG),
    .REPEAT_CYCLES(RP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btn      (btn),
    .repeat_en(repeat_en),
    .held_o   (held_o),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o),
    .repeat_o (repeat_o)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: raw samples delayed two edges, run-length debounce,
  // timestamp-based long press and an enabled-edge tally for repeats.
  logic [W-1:0] raw_q[$];
  logic [W-1:0] m_held, m_press, m_rel, m_long, m_rep;
  int           run_len[W], t_press[W], en_run[W];
  bit           long_done[W];
  int           cyc = 0;

  int first_ev[4], cnt_ev[4];

  typedef struct {
    logic [W-1:0] btn;
    logic [W-1:0] en;
    int           n;
    logic [W-1:0] held;
    int           press, rel, lng, rpt;
  } seg_t;
  seg_t segs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    raw_q.delete();
    raw_q.push_back('0);
    raw_q.push_back('0);
    {m_held, m_press, m_rel, m_long, m_rep} = '0;
    for (int c = 0; c < W; c++) begin
      run_len[c] = 0; t_press[c] = 0; en_run[c] = 0; long_done[c] = 0;
    end
  endtask

  task automatic model_step();
    logic [W-1:0] s2;
    logic rise, fall;
    s2 = raw_q.pop_front();
    raw_q.push_back(btn);
    cyc++;
    {m_press, m_rel, m_long, m_rep} = '0;
    for (int c = 0; c < W; c++) begin
      rise = 1'b0;
      fall = 1'b0;
      if (s2[c] != m_held[c]) begin
        run_len[c]++;
        if (run_len[c] == DB) begin
          run_len[c] = 0;
          m_held[c]  = s2[c];
          rise = s2[c];
          fall = !s2[c];
        end
      end else begin
        run_len[c] = 0;
      end
      if (rise) begin
        m_press[c] = 1'b1; t_press[c] = cyc; long_done[c] = 0;
      end else if (fall) begin
        m_rel[c] = 1'b1; long_done[c] = 0; en_run[c] = 0;
      end else if (m_held[c] && !long_done[c]) begin
        if (cyc - t_press[c] == LG) begin
          m_long[c] = 1'b1; long_done[c] = 1; en_run[c] = 0;
        end
      end else if (m_held[c] && long_done[c]) begin
        if (!repeat_en[c]) begin
          en_run[c] = 0;
        end else begin
          en_run[c]++;
          if (en_run[c] == RP) begin
            m_rep[c] = 1'b1; en_run[c] = 0;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("cycle", 32'({held_o, press_o, release_o, long_o, repeat_o}),
          32'({m_held, m_press, m_rel, m_long, m_rep}));
  endtask

  // Called just after a falling edge; leaves rst_n released mid-low-phase.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", 32'({held_o, press_o, release_o, long_o, repeat_o}), 32'd0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] ev(input int k);
    case (k)
      0:       return press_o;
      1:       return release_o;
      2:       return long_o;
      default: return repeat_o;
    endcase
  endfunction

  // Run n cycles, recording per event kind the first cycle index and count on channel ch.
  task automatic run(input int n, input int ch);
    logic [W-1:0] v;
    for (int k = 0; k < 4; k++) begin
      first_ev[k] = -1; cnt_ev[k] = 0;
    end
    for (int i = 0; i < n; i++) begin
      tick();
      for (int k = 0; k < 4; k++) begin
        v = ev(k);
        if (v[ch]) begin
          if (first_ev[k] < 0) first_ev[k] = i;
          cnt_ev[k]++;
        end
      end
    end
  endtask

  int cp, cr, cl, ct, bounce_press;
  int dur[W];

  initial begin
    segs[0] = '{4'b0000, 4'b0000,  5, 4'b0000, 0, 0, 0, 0};
    segs[1] = '{4'b0001, 4'b0000, 10, 4'b0001, 1, 0, 0, 0};
    segs[2] = '{4'b0001, 4'b0000, 50, 4'b0001, 0, 0, 1, 0};
    segs[3] = '{4'b0000, 4'b0000, 10, 4'b0000, 0, 1, 0, 0};
    segs[4] = '{4'b0100, 4'b0100, 60, 4'b0100, 1, 0, 1, 6};
    segs[5] = '{4'b0100, 4'b0000, 12, 4'b0100, 0, 0, 0, 0};
    segs[6] = '{4'b0100, 4'b0100, 12, 4'b0100, 0, 0, 0, 2};
    segs[7] = '{4'b0000, 4'b0100, 10, 4'b0000, 0, 1, 0, 1};
    segs[8] = '{4'b1010, 4'b0000,  8, 4'b1010, 2, 0, 0, 0};
    segs[9] = '{4'b0000, 4'b0000,  8, 4'b0000, 0, 2, 0, 0};

    rst_n = 1'b1;
    btn = '0;
    repeat_en = '0;
    #1;
    do_reset();

    // Table-driven segments, pulse totals summed over channels.
    foreach (segs[i]) begin
      btn = segs[i].btn;
      repeat_en = segs[i].en;
      cp = 0; cr = 0; cl = 0; ct = 0;
      repeat (segs[i].n) begin
        tick();
        cp += $countones(press_o);
        cr += $countones(release_o);
        cl += $countones(long_o);
        ct += $countones(repeat_o);
      end
      check("seg_held", 32'(held_o), 32'(segs[i].held));
      check("seg_press", 32'(cp), 32'(segs[i].press));
      check("seg_release", 32'(cr), 32'(segs[i].rel));
      check("seg_long", 32'(cl), 32'(segs[i].lng));
      check("seg_repeat", 32'(ct), 32'(segs[i].rpt));
    end

    // Clean step and release latency on channel 0.
    do_reset();
    btn = 4'b0001;
    run(10, 0);
    check("step_press_at", 32'(first_ev[0]), 32'd5);
    check("step_press_cnt", 32'(cnt_ev[0]), 32'd1);
    run(40, 0);
    btn = 4'b0000;
    run(10, 0);
    check("step_release_at", 32'(first_ev[1]), 32'd5);
    check("step_release_cnt", 32'(cnt_ev[1]), 32'd1);

    // Bounce on channel 1: 3 high / 2 low, then stable high.
    do_reset();
    bounce_press = 0;
    for (int p = 0; p < 6; p++) begin
      btn[1] = 1'b1;
      run(3, 1);
      bounce_press += cnt_ev[0] + cnt_ev[1];
      btn[1] = 1'b0;
      run(2, 1);
      bounce_press += cnt_ev[0] + cnt_ev[1];
    end
    check("bounce_no_event", 32'(bounce_press), 32'd0);
    btn[1] = 1'b1;
    run(10, 1);
    check("bounce_press_at", 32'(first_ev[0]), 32'd5);
    check("bounce_press_cnt", 32'(cnt_ev[0]), 32'd1);
    check("bounce_no_release", 32'(cnt_ev[1]), 32'd0);

    // Long press and auto-repeat on channel 2.
    do_reset();
    btn = 4'b0100;
    repeat_en = 4'b0100;
    run(10, 2);
    check("long_press_at", 32'(first_ev[0]), 32'd5);
    run(20, 2);
    check("long_at", 32'(first_ev[2]), 32'd15);
    run(20, 2);
    check("repeat_first", 32'(first_ev[3]), 32'd0);
    check("repeat_cnt", 32'(cnt_ev[3]), 32'd4);
    repeat_en = 4'b0000;
    run(7, 2);
    check("repeat_off_cnt", 32'(cnt_ev[3]), 32'd0);
    repeat_en = 4'b0100;
    run(10, 2);
    check("repeat_resume_at", 32'(first_ev[3]), 32'd4);
    check("repeat_resume_cnt", 32'(cnt_ev[3]), 32'd2);

    // Fall coinciding with the long threshold on channel 0.
    do_reset();
    btn = 4'b0001;
    repeat_en = 4'b0000;
    run(20, 0);
    check("coin_press_at", 32'(first_ev[0]), 32'd5);
    btn = 4'b0000;
    run(10, 0);
    check("coin_release_at", 32'(first_ev[1]), 32'd5);
    check("coin_long_cnt", 32'(cnt_ev[2]), 32'd0);

    // Reset while long-held on channel 3, button kept held across it.
    do_reset();
    btn = 4'b1000;
    run(30, 3);
    check("rst_long_cnt", 32'(cnt_ev[2]), 32'd1);
    do_reset();
    run(10, 3);
    check("rst_repress_at", 32'(first_ev[0]), 32'd5);
    check("rst_no_release", 32'(cnt_ev[1]), 32'd0);

    // Randomised activity on all channels against the model.
    do_reset();
    btn = '0;
    repeat_en = '0;
    for (int c = 0; c < W; c++) dur[c] = int'($urandom_range(1, 10));
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < W; c++) begin
        if (dur[c] == 0) begin
          btn[c] = ~btn[c];
          dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 60))
                                                : int'($urandom_range(1, 8));
        end else begin
          dur[c]--;
        end
        if ($urandom_range(0, 19) == 0) repeat_en[c] = ~repeat_en[c];
      end
      if (i == 1500) do_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
